// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Purpose:
//   Consumer side of the program-counter interface in the RV32I 5-stage
//   pipeline. Each cycle the PC presented by the program counter is issued
//   as an instruction-memory request. In-order responses are paired with
//   the PC they were fetched from and buffered in a DEPTH-entry FIFO that
//   feeds the IF/ID stage. RetainPC asks the counter to hold when the
//   request cannot be accepted; Flush discards every queued or in-flight
//   fetch older than the redirect.
//
// Parameters:
//   WORD_LENGTH - width of PC, memory address and instruction word.
//   DEPTH       - FIFO entries and the bound on outstanding-plus-queued
//                 fetches (power of 2, at least 2).
//
// Ports:
//   CLK, Reset          - clock; asynchronous active-high reset.
//   PC, PCValid         - fetch address from the program counter.
//   Flush               - redirect; kill all older fetches.
//   RetainPC            - program counter must hold PC this cycle.
//   imem_req_*          - valid/ready request channel, addr = PC.
//   imem_rsp_*          - in-order response channel (latency >= 1).
//   IF_ID_Valid/Ready   - head-entry handshake with decode.
//   IF_ID_PC/Instr      - PC/instruction pair at the FIFO head.
//
// Build option:
//   FETCH_QUEUE_BYPASS_EN - when defined, a response that arrives while the
//   FIFO is empty and nothing is being dropped is presented on IF_ID_*
//   combinationally in the same cycle, and is never written if decode takes
//   it. When undefined, every response is registered into the FIFO first.
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int WORD_LENGTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [WORD_LENGTH-1:0] PC,
    input  logic                   PCValid,
    input  logic                   Flush,
    output logic                   RetainPC,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [WORD_LENGTH-1:0] imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [WORD_LENGTH-1:0] imem_rsp_data,
    output logic                   IF_ID_Valid,
    input  logic                   IF_ID_Ready,
    output logic [WORD_LENGTH-1:0] IF_ID_PC,
    output logic [WORD_LENGTH-1:0] IF_ID_Instr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] ONE_P   = PW'(1);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    // Instruction FIFO storage and pointers.
    logic [WORD_LENGTH-1:0] r_pcMem    [DEPTH];
    logic [WORD_LENGTH-1:0] r_instrMem [DEPTH];
    logic [PW-1:0]          r_head;
    logic [PW-1:0]          r_tail;
    logic [CW-1:0]          r_count;

    // Address tags of accepted requests, oldest first.
    logic [WORD_LENGTH-1:0] r_tagMem [DEPTH];
    logic [PW-1:0]          r_tagHead;
    logic [PW-1:0]          r_tagTail;

    // Requests accepted but not yet answered, and how many of those
    // answers belong to fetches killed by a redirect.
    logic [CW-1:0]          r_outstanding;
    logic [CW-1:0]          r_dropCnt;

    logic                   w_credit;
    logic                   w_accept;
    logic                   w_fifoEmpty;
    logic                   w_dropping;
    logic                   w_rspKeep;
    logic                   w_bypass;
    logic                   w_fifoPush;
    logic                   w_fifoPop;
    logic [WORD_LENGTH-1:0] w_rspTag;
    logic [CW:0]            w_occupancy;

    // Request side: a fetch may be issued only while every slot it could
    // eventually occupy is guaranteed free, which keeps the FIFO from ever
    // overflowing no matter how the responses are timed.
    always_comb begin
        w_occupancy    = {1'b0, r_count} + {1'b0, r_outstanding};
        w_credit       = (w_occupancy < DEPTH_C);
        imem_req_valid = !Reset && PCValid && w_credit && !Flush;
        imem_req_addr  = PC;
        w_accept       = imem_req_valid && imem_req_ready;
        // On Flush the counter loads the redirect target, so it is never held.
        RetainPC       = !Reset && PCValid && !w_accept && !Flush;
    end

    // Response side: a response that lands in a redirect cycle belongs to
    // the killed path, so it is dropped just like those counted in DropCnt.
    always_comb begin
        w_fifoEmpty = (r_count == '0);
        w_dropping  = (r_dropCnt != '0);
        w_rspKeep   = imem_rsp_valid && !w_dropping && !Flush;
        w_rspTag    = r_tagMem[r_tagHead];
`ifdef FETCH_QUEUE_BYPASS_EN
        w_bypass    = !Reset && w_fifoEmpty && w_rspKeep;
`else
        w_bypass    = 1'b0;
`endif
        w_fifoPop   = !w_fifoEmpty && IF_ID_Ready;
        w_fifoPush  = w_rspKeep && !(w_bypass && IF_ID_Ready);
    end

    // Decode-facing outputs; the fields read as zero while nothing is valid.
    always_comb begin
        IF_ID_Valid = !w_fifoEmpty || w_bypass;
        IF_ID_PC    = '0;
        IF_ID_Instr = '0;
        if (!w_fifoEmpty) begin
            IF_ID_PC    = r_pcMem[r_head];
            IF_ID_Instr = r_instrMem[r_head];
        end else if (w_bypass) begin
            IF_ID_PC    = w_rspTag;
            IF_ID_Instr = imem_rsp_data;
        end
    end

    // FIFO occupancy and pointers. A redirect empties the FIFO outright.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (Flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_fifoPush) begin
                r_tail <= r_tail + ONE_P;
            end
            if (w_fifoPop) begin
                r_head <= r_head + ONE_P;
            end
            if (w_fifoPush && !w_fifoPop) begin
                r_count <= r_count + ONE_C;
            end else if (!w_fifoPush && w_fifoPop) begin
                r_count <= r_count - ONE_C;
            end
        end
    end

    // FIFO payload. A push into a full FIFO only happens together with a
    // pop, and the slot being overwritten is the one leaving this cycle.
    always_ff @(posedge CLK) begin
        if (w_fifoPush && !Flush) begin
            r_pcMem[r_tail]    <= w_rspTag;
            r_instrMem[r_tail] <= imem_rsp_data;
        end
    end

    // Tag FIFO pointers. Every response consumes a tag, kept or dropped,
    // so the tags stay aligned with the memory across redirects.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_tagHead <= '0;
            r_tagTail <= '0;
        end else begin
            if (w_accept) begin
                r_tagTail <= r_tagTail + ONE_P;
            end
            if (imem_rsp_valid) begin
                r_tagHead <= r_tagHead + ONE_P;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_tagMem[r_tagTail] <= PC;
        end
    end

    // Outstanding and drop accounting. On a redirect every outstanding
    // fetch is stale; a response arriving in that same cycle is already
    // dropped, so it is left out of the new DropCnt. Recomputing rather
    // than adding avoids double-counting on back-to-back redirects.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_outstanding <= '0;
            r_dropCnt     <= '0;
        end else begin
            if (w_accept && !imem_rsp_valid) begin
                r_outstanding <= r_outstanding + ONE_C;
            end else if (!w_accept && imem_rsp_valid) begin
                r_outstanding <= r_outstanding - ONE_C;
            end

            if (Flush) begin
                r_dropCnt <= imem_rsp_valid ? (r_outstanding - ONE_C) : r_outstanding;
            end else if (imem_rsp_valid && w_dropping) begin
                r_dropCnt <= r_dropCnt - ONE_C;
            end
        end
    end

`ifndef SYNTHESIS
    // Protocol checks on the memory side: a response needs a matching
    // request and must never find the FIFO already full.
    always_ff @(posedge CLK) begin
        if (!Reset && imem_rsp_valid) begin
            assert (r_count != FULL_C);
            assert (r_outstanding != '0);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Drives fetch_queue with a program-counter model and an in-order memory
// model, and compares every cycle against a queue-based reference of the
// fetch queue's observable behaviour. Directed phases cover streaming,
// decode backpressure, memory stall, redirects with fetches in flight,
// a redirect coinciding with a response and a pop, and reset while full;
// a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int WL    = 32;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          Reset;
    logic [WL-1:0] PC;
    logic          PCValid;
    logic          Flush;
    logic          RetainPC;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [WL-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [WL-1:0] imem_rsp_data;
    logic          IF_ID_Valid;
    logic          IF_ID_Ready;
    logic [WL-1:0] IF_ID_PC;
    logic [WL-1:0] IF_ID_Instr;

    always #5 CLK = ~CLK;

    fetch_queue #(.WORD_LENGTH(WL), .DEPTH(DEPTH)) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .PC             (PC),
        .PCValid        (PCValid),
        .Flush          (Flush),
        .RetainPC       (RetainPC),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .IF_ID_Valid    (IF_ID_Valid),
        .IF_ID_Ready    (IF_ID_Ready),
        .IF_ID_PC       (IF_ID_PC),
        .IF_ID_Instr    (IF_ID_Instr)
    );

    typedef struct {
        logic [WL-1:0] pc;
        logic [WL-1:0] instr;
    } entry_t;

    typedef struct {
        logic [WL-1:0] pc;
        int            due;
    } req_t;

    // Reference state: queued entries, memory requests in flight, and the
    // number of in-flight answers that belong to killed fetches.
    entry_t        mFifo[$];
    req_t          mPend[$];
    int            mOut;
    int            mDrop;
    int            cyc;
    logic [WL-1:0] pcReg;
    bit            pcValidReg;
    int            maxExtraLat;

    int            errors;
    int            checks;

    bit            watchBad;
    int            badSeen;
    bit            gotFirst;
    logic [WL-1:0] firstPC;

    function automatic logic [WL-1:0] instrOf(input logic [WL-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [WL-1:0] got,
                               input logic [WL-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, compare outputs
    // mid-cycle against the reference, then advance the reference.
    task automatic applyStimulus(input bit flush, input bit memRdy, input bit decRdy,
                                 input bit rspEn, input logic [WL-1:0] target);
        bit   rsp;
        bit   eReqV;
        bit   eAcc;
        bit   eRet;
        bit   eByp;
        bit   eV;
        int   occ;
        req_t head;

        @(posedge CLK);
        #1;
        rsp            = rspEn && (mPend.size() > 0) && (mPend[0].due <= cyc);
        PC             = pcReg;
        PCValid        = pcValidReg;
        Flush          = flush;
        imem_req_ready = memRdy;
        IF_ID_Ready    = decRdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? instrOf(mPend[0].pc) : WL'($urandom);
        #3;

        occ   = mFifo.size() + mOut;
        eReqV = pcValidReg && (occ < DEPTH) && !flush;
        eAcc  = eReqV && memRdy;
        eRet  = pcValidReg && !eAcc && !flush;
        eByp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        eByp  = (mFifo.size() == 0) && (mDrop == 0) && rsp && !flush;
`endif
        eV    = (mFifo.size() > 0) || eByp;

        checkOutput("RetainPC", RetainPC, eRet);
        checkOutput("imem_req_valid", imem_req_valid, eReqV);
        if (eReqV) begin
            checkOutput("imem_req_addr", imem_req_addr, pcReg);
        end
        checkOutput("IF_ID_Valid", IF_ID_Valid, eV);
        if (mFifo.size() > 0) begin
            checkOutput("IF_ID_PC", IF_ID_PC, mFifo[0].pc);
            checkOutput("IF_ID_Instr", IF_ID_Instr, mFifo[0].instr);
        end else if (eByp) begin
            checkOutput("IF_ID_PC_byp", IF_ID_PC, mPend[0].pc);
            checkOutput("IF_ID_Instr_byp", IF_ID_Instr, instrOf(mPend[0].pc));
        end

        if (watchBad && IF_ID_Valid) begin
            if (IF_ID_PC == 32'h40 || IF_ID_PC == 32'h44) begin
                badSeen++;
            end
            if (!gotFirst) begin
                gotFirst = 1'b1;
                firstPC  = IF_ID_PC;
            end
        end

        head = '{pc: '0, due: 0};
        if (rsp) begin
            head = mPend.pop_front();
        end
        if (flush) begin
            mDrop = mOut - (rsp ? 1 : 0);
            mFifo.delete();
        end else begin
            if (mFifo.size() > 0 && decRdy) begin
                void'(mFifo.pop_front());
            end
            if (rsp) begin
                if (mDrop > 0) begin
                    mDrop--;
                end else if (!(eByp && decRdy)) begin
                    mFifo.push_back('{pc: head.pc, instr: instrOf(head.pc)});
                end
            end
        end
        mOut = mOut + (eAcc ? 1 : 0) - (rsp ? 1 : 0);
        if (eAcc) begin
            mPend.push_back('{pc: pcReg, due: cyc + 1 + int'($urandom_range(maxExtraLat, 0))});
        end

        if (flush) begin
            pcReg = target;
        end else if (!pcValidReg) begin
            pcReg      = '0;
            pcValidReg = 1'b1;
        end else if (eAcc) begin
            pcReg = pcReg + 32'd4;
        end
        cyc++;
    endtask

    // Reset while the queue may be busy: state must clear immediately.
    task automatic applyReset();
        @(posedge CLK);
        #1;
        Reset          = 1'b1;
        imem_rsp_valid = 1'b0;
        #1;
        checkOutput("rst_IF_ID_Valid", IF_ID_Valid, 1'b0);
        checkOutput("rst_RetainPC", RetainPC, 1'b0);
        checkOutput("rst_req_valid", imem_req_valid, 1'b0);
        checkOutput("rst_IF_ID_PC", IF_ID_PC, '0);
        checkOutput("rst_IF_ID_Instr", IF_ID_Instr, '0);
        mFifo.delete();
        mPend.delete();
        mOut       = 0;
        mDrop      = 0;
        pcReg      = 32'hFFFF_FFFC;
        pcValidReg = 1'b0;
        PC         = pcReg;
        PCValid    = 1'b0;
        Flush      = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        cyc            = 0;
        mOut           = 0;
        mDrop          = 0;
        maxExtraLat    = 0;
        watchBad       = 1'b0;
        badSeen        = 0;
        gotFirst       = 1'b0;
        firstPC        = '0;
        pcReg          = 32'hFFFF_FFFC;
        pcValidReg     = 1'b0;
        Reset          = 1'b1;
        PC             = pcReg;
        PCValid        = 1'b1;
        Flush          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        IF_ID_Ready    = 1'b0;

        applyReset();

        // Streaming with single-cycle memory and a free-running decoder.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, '0);

        // Decode backpressure fills the queue until the counter is held.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
        checkOutput("bp_retain", RetainPC, 1'b1);
        checkOutput("bp_req_valid", imem_req_valid, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, '0);
        checkOutput("bp_first_pop_retain", RetainPC, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, '0);
        checkOutput("bp_resume", RetainPC, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, '0);

        // Memory stall at PC 0x20: held for three cycles, then one accept.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h20);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
            checkOutput("stall_retain", RetainPC, 1'b1);
            checkOutput("stall_addr", imem_req_addr, 32'h20);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, '0);
        checkOutput("stall_accept", RetainPC, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, '0);
        checkOutput("stall_next_addr", imem_req_addr, 32'h24);

        // Redirect with 0x40 and 0x44 in flight; both must be dropped.
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h40);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
        watchBad = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h100);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, '0);
        watchBad = 1'b0;
        checkOutput("flush_first_pc", firstPC, 32'h100);
        checkOutput("flush_bad_seen", badSeen, 0);

        // Redirect in the same cycle as a response and a head pop.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("flush_coinc_valid", IF_ID_Valid, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, '0);

        // Reset while the queue holds three entries.
        for (int i = 0; i < 20 && mFifo.size() < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
        end
        checkOutput("pre_rst_valid", IF_ID_Valid, 1'b1);
        applyReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("post_rst_addr", imem_req_addr, 32'h0);
        checkOutput("post_rst_accept", RetainPC, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("post_rst_full_credit", RetainPC, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("post_rst_no_credit", RetainPC, 1'b1);

        // Randomized traffic with variable memory latency.
        maxExtraLat = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(599, 0) == 0) begin
                applyReset();
            end else begin
                applyStimulus($urandom_range(99, 0) < 5,
                              $urandom_range(99, 0) < 70,
                              $urandom_range(99, 0) < 60,
                              $urandom_range(99, 0) < 70,
                              {20'h0, 10'($urandom_range(1023, 0)), 2'b00});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Consumer side of the program-counter interface in the RV32I 5-stage pipeline.
- Each cycle it takes the PC the counter presents and issues it as an instruction-memory request.
- In-order responses are buffered in a DEPTH-entry FIFO and presented to the IF/ID stage as PC/instruction pairs.
- Generates RetainPC back to the program counter when it cannot accept, and discards queued or in-flight fetches on a redirect (Flush).

Parameters:
- WORD_LENGTH, 32, width of PC, address and instruction.
- DEPTH, 4, FIFO entries and maximum outstanding-plus-queued fetches; power of 2, ≥2.

Ports:
- CLK  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- PC  in  WORD_LENGTH  fetch address from the program counter.
- PCValid  in  1  PC is a real fetch address; low in the cycle after reset while PC = -4.
- Flush  in  1  redirect (taken branch, Jump or JumpReg); kill all older fetches.
- RetainPC  out  1  program counter must hold PC this cycle.
- imem_req_valid  out  1  memory request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  WORD_LENGTH  request address, equal to PC.
- imem_rsp_valid  in  1  response data valid; responses arrive in request order, latency ≥1.
- imem_rsp_data  in  WORD_LENGTH  instruction word.
- IF_ID_Valid  out  1  head entry valid.
- IF_ID_Ready  in  1  decode consumes the head this cycle.
- IF_ID_PC  out  WORD_LENGTH  PC of the head entry.
- IF_ID_Instr  out  WORD_LENGTH  instruction of the head entry.

Behaviour:
- Reset (async): FIFO empty, head/tail pointers 0, Outstanding = 0, DropCnt = 0, IF_ID_Valid = 0, IF_ID_PC = 0, IF_ID_Instr = 0. RetainPC and imem_req_valid are combinational; both are 0 while Reset is high.
- Credit: Count + Outstanding < DEPTH, where Count is the FIFO occupancy.
- imem_req_valid = PCValid & credit & !Flush; imem_req_addr = PC.
- Accept = imem_req_valid & imem_req_ready.
- RetainPC = PCValid & !Accept & !Flush. On Flush the counter loads the redirect target, so this block must not hold it.
- Accept pushes the request's PC into an address-tag FIFO of depth DEPTH, in order. Outstanding increments on Accept and decrements on a response; both in one cycle leaves it unchanged.
- Response with DropCnt = 0: pop the tag, write {tag, imem_rsp_data} to the FIFO tail.
- Response with DropCnt > 0: pop the tag, discard the data, decrement DropCnt.
- Head pop: occurs when IF_ID_Valid & IF_ID_Ready. IF_ID_* come from the FIFO head; no bubble between back-to-back entries.
- Flush, cycle T:
  - FIFO cleared at T+1; IF_ID_Valid = 0 at T+1.
  - DropCnt = Outstanding minus (1 if a response arrives in T). That response is itself dropped.
  - No request issued in T.
- Flush while DropCnt > 0: DropCnt is recomputed by the same rule (no double-count).
- Credit accounting prevents FIFO overflow. A response arriving with Count = DEPTH is a protocol violation; assert it in simulation.
- Simultaneous push and pop with the FIFO full is legal; occupancy is unchanged.
- Reset mid-operation: all state is cleared immediately. Memory-side responses after Reset are the environment's responsibility.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined: when the FIFO is empty, DropCnt = 0 and a response arrives, IF_ID_Valid/PC/Instr present the response combinationally in the same cycle. If IF_ID_Ready is high, the entry is consumed and never written. This gives 0 added cycles of latency.
- Undefined: every response is registered into the FIFO; it appears at IF_ID_* the cycle after imem_rsp_valid.

Test Plan:
- Streaming: PC = 0,4,8,12 with ready = 1, response latency 1, IF_ID_Ready = 1 -> IF_ID_PC 0,4,8,12 with matching data on consecutive cycles; RetainPC stays 0.
- Backpressure: IF_ID_Ready = 0, DEPTH = 4 -> after 4 accepts, RetainPC = 1 and imem_req_valid = 0. Raise ready -> next accept one cycle after the first pop.
- Memory stall: imem_req_ready = 0 for 3 cycles at PC = 0x20 -> RetainPC = 1 for 3 cycles, imem_req_addr held at 0x20, exactly one request accepted.
- Flush with 2 in flight (0x40, 0x44), redirect to 0x100 -> both responses dropped; next IF_ID_PC = 0x100; no entry with 0x40/0x44 ever valid.
- Flush coincident with a response and a FIFO pop -> FIFO empty at T+1, DropCnt = Outstanding-1, no corrupt entry.
- Reset asserted with FIFO holding 3 entries -> IF_ID_Valid = 0, RetainPC = 0, Outstanding = 0 immediately. First fetch after PCValid is PC = 0.
